// File: rtl/gadget_pkg.sv
// Shared types and helpers for the gadget slot scheduler.
// One-hot scheduler states, the empty-slot type code and the slot-index width rule.
package gadget_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        SCAN  = 4'b0010,
        SERVE = 4'b0100,
        DONE  = 4'b1000
    } sched_state_e;

    localparam logic [7:0] GADGET_NONE = 8'd0;

    function automatic int slot_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gadget_scheduler_if.sv
// Spawn and per-slot gadget signals between the scheduler and the gadget array.
// Names are from the scheduler's point of view: i_ flows into it, o_ flows out of it.
interface gadget_scheduler_if #(
    parameter int N_GADGET       = 4,
    parameter int GADGET_BIT_CNT = 3,
    parameter int PIXELX_BIT_CNT = 10,
    parameter int PIXELY_BIT_CNT = 9
);
    logic                               i_spawn_valid;
    logic [GADGET_BIT_CNT-1:0]          i_spawn_type;
    logic [PIXELX_BIT_CNT-1:0]          i_spawn_x;
    logic [PIXELY_BIT_CNT-1:0]          i_spawn_y;
    logic                               o_spawn_drop;
    logic [N_GADGET-1:0]                o_gadget_gen;
    logic [PIXELX_BIT_CNT-1:0]          o_gadget_initX;
    logic [PIXELY_BIT_CNT-1:0]          o_gadget_initY;
    logic [GADGET_BIT_CNT-1:0]          o_gadget_type;
    logic [N_GADGET*GADGET_BIT_CNT-1:0] i_gadget_type;
    logic [N_GADGET-1:0]                o_gadget_req;
    logic [N_GADGET-1:0]                i_gadget_ack;
    logic [N_GADGET-1:0]                i_gadget_frame_term;

    modport master (
        input  i_spawn_valid, i_spawn_type, i_spawn_x, i_spawn_y,
        input  i_gadget_type, i_gadget_ack, i_gadget_frame_term,
        output o_spawn_drop, o_gadget_gen, o_gadget_initX, o_gadget_initY,
        output o_gadget_type, o_gadget_req
    );

    modport slave (
        output i_spawn_valid, i_spawn_type, i_spawn_x, i_spawn_y,
        output i_gadget_type, i_gadget_ack, i_gadget_frame_term,
        input  o_spawn_drop, o_gadget_gen, o_gadget_initX, o_gadget_initY,
        input  o_gadget_type, o_gadget_req
    );

endinterface

// File: rtl/gadget_slot_alloc.sv
// Lowest-index free-slot encoder: a slot is free when its type is empty and it is not reserved.
module gadget_slot_alloc
    import gadget_pkg::*;
#(
    parameter int N_GADGET       = 4,
    parameter int GADGET_BIT_CNT = 3,
    localparam int IDX_W         = slot_idx_width(N_GADGET)
) (
    input  logic [N_GADGET*GADGET_BIT_CNT-1:0] i_type,
    input  logic [N_GADGET-1:0]                i_resv,
    output logic                               o_found,
    output logic [IDX_W-1:0]                   o_idx
);

    localparam logic [GADGET_BIT_CNT-1:0] NONE_T = GADGET_NONE[GADGET_BIT_CNT-1:0];

    logic [N_GADGET-1:0] w_free;

    // Per-slot free flags
    always_comb begin
        w_free = '0;
        for (int i = 0; i < N_GADGET; i++) begin
            w_free[i] = (i_type[i*GADGET_BIT_CNT +: GADGET_BIT_CNT] == NONE_T) && !i_resv[i];
        end
    end

    // Walk from the top so the lowest free index is the one left standing
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N_GADGET - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end else begin
                o_found = o_found;
            end
        end
    end

endmodule

// File: rtl/gadget_scheduler.sv
// Gadget slot scheduler: allocates slots for new gadgets and, once per frame,
// polls every live slot in index order over the req/frame_term handshake.
module gadget_scheduler
    import gadget_pkg::*;
#(
    parameter int N_GADGET       = 4,
    parameter int GADGET_BIT_CNT = 3,
    parameter int PIXELX_BIT_CNT = 10,
    parameter int PIXELY_BIT_CNT = 9,
    parameter int SERVE_TMO      = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cal_frame,
    output logic               o_frame_done,
    output logic               o_busy,
    output logic               o_err_tmo,
    gadget_scheduler_if.master bus
);

    localparam int IDX_W = slot_idx_width(N_GADGET);
    localparam int TMO_W = $clog2(SERVE_TMO);
    localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(N_GADGET - 1);
    localparam logic [TMO_W-1:0]          TMO_LAST = TMO_W'(SERVE_TMO - 1);
    localparam logic [GADGET_BIT_CNT-1:0] NONE_T   = GADGET_NONE[GADGET_BIT_CNT-1:0];
    localparam logic [N_GADGET-1:0]       SLOT0    = N_GADGET'(1'b1);

    sched_state_e              r_state;
    sched_state_e              w_state_n;
    logic [IDX_W-1:0]          r_idx;
    logic [IDX_W-1:0]          w_idx_n;
    logic [TMO_W-1:0]          r_timer;
    logic [N_GADGET-1:0]       r_resv;
    logic [N_GADGET-1:0]       r_req;
    logic [N_GADGET-1:0]       r_gen;
    logic [PIXELX_BIT_CNT-1:0] r_initx;
    logic [PIXELY_BIT_CNT-1:0] r_inity;
    logic [GADGET_BIT_CNT-1:0] r_type;
    logic                      r_drop;
    logic                      r_frame_done;
    logic                      r_busy;
    logic                      r_err_tmo;

    logic [N_GADGET-1:0]       w_occ;
    logic [N_GADGET-1:0]       w_slot_sel;
    logic                      w_live_sel;
    logic                      w_term_sel;
    logic                      w_last;
    logic                      w_tmo;
    logic                      w_tmo_abort;
    logic                      w_found;
    logic [IDX_W-1:0]          w_free_idx;
    logic                      w_spawn_req;
    logic                      w_hit;
    logic [N_GADGET-1:0]       w_gen_n;
    logic [N_GADGET-1:0]       w_resv_n;

    gadget_slot_alloc #(
        .N_GADGET       (N_GADGET),
        .GADGET_BIT_CNT (GADGET_BIT_CNT)
    ) u_alloc (
        .i_type  (bus.i_gadget_type),
        .i_resv  (r_resv),
        .o_found (w_found),
        .o_idx   (w_free_idx)
    );

    // Slot occupancy as seen by the scan: a non-empty type register
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < N_GADGET; i++) begin
            w_occ[i] = (bus.i_gadget_type[i*GADGET_BIT_CNT +: GADGET_BIT_CNT] != NONE_T);
        end
    end

    assign w_slot_sel  = SLOT0 << r_idx;
    assign w_live_sel  = |(w_slot_sel & (w_occ | r_resv));
    assign w_term_sel  = |(w_slot_sel & bus.i_gadget_frame_term);
    assign w_last      = (r_idx == LAST_IDX);
    assign w_tmo       = (r_timer == TMO_LAST);
    assign w_tmo_abort = (r_state == SERVE) && w_tmo && !w_term_sel;

    assign w_spawn_req = bus.i_spawn_valid && (bus.i_spawn_type != NONE_T);
    assign w_hit       = w_spawn_req && w_found;
    assign w_gen_n     = w_hit ? (SLOT0 << w_free_idx) : '0;
    // A reservation lives until the slot's own type register shows the new gadget
    assign w_resv_n    = (r_resv & ~w_occ) | w_gen_n;

    // Next-state and next-index logic
    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        case (r_state)
            IDLE: begin
                if (i_cal_frame) begin
                    w_state_n = SCAN;
                    w_idx_n   = '0;
                end else begin
                    w_state_n = IDLE;
                end
            end
            SCAN: begin
                if (w_live_sel) begin
                    w_state_n = SERVE;
                end else if (w_last) begin
                    w_state_n = DONE;
                end else begin
                    w_idx_n = r_idx + IDX_W'(1);
                end
            end
            SERVE: begin
                if (w_term_sel || w_tmo) begin
                    if (w_last) begin
                        w_state_n = DONE;
                    end else begin
                        w_state_n = SCAN;
                        w_idx_n   = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_state_n = SERVE;
                end
            end
            DONE: begin
                w_state_n = IDLE;
                w_idx_n   = '0;
            end
            default: begin
                w_state_n = IDLE;
                w_idx_n   = '0;
            end
        endcase
    end

    // FSM state, slot index and serve timer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_n;
            r_idx   <= w_idx_n;
            r_timer <= (r_state == SERVE) ? (r_timer + TMO_W'(1)) : '0;
        end
    end

    // Frame-side registered outputs; frame_done trails the DONE cycle and busy covers it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req        <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_tmo    <= 1'b0;
        end else begin
            r_req        <= (w_state_n == SERVE) ? (SLOT0 << w_idx_n) : '0;
            r_busy       <= (w_state_n != IDLE) || (r_state == DONE);
            r_frame_done <= (r_state == DONE);
            r_err_tmo    <= r_err_tmo | w_tmo_abort;
        end
    end

    // Spawn path: runs independently of the frame FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resv  <= '0;
            r_gen   <= '0;
            r_drop  <= 1'b0;
            r_initx <= '0;
            r_inity <= '0;
            r_type  <= '0;
        end else begin
            r_resv <= w_resv_n;
            r_gen  <= w_gen_n;
            r_drop <= w_spawn_req && !w_found;
            if (w_hit) begin
                r_initx <= bus.i_spawn_x;
                r_inity <= bus.i_spawn_y;
                r_type  <= bus.i_spawn_type;
            end else begin
                r_initx <= r_initx;
                r_inity <= r_inity;
                r_type  <= r_type;
            end
        end
    end

    assign o_frame_done       = r_frame_done;
    assign o_busy             = r_busy;
    assign o_err_tmo          = r_err_tmo;
    assign bus.o_gadget_req   = r_req;
    assign bus.o_gadget_gen   = r_gen;
    assign bus.o_spawn_drop   = r_drop;
    assign bus.o_gadget_initX = r_initx;
    assign bus.o_gadget_initY = r_inity;
    assign bus.o_gadget_type  = r_type;

endmodule

// File: tb/tb_gadget_scheduler.sv
// Directed bench for gadget_scheduler: a spawn vector table plus hand-written frame sequences.
module tb_gadget_scheduler;

    localparam int N   = 4;
    localparam int GB  = 3;
    localparam int XB  = 10;
    localparam int YB  = 9;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cal = 1'b0;
    logic o_fd;
    logic o_busy;
    logic o_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gadget_scheduler_if #(
        .N_GADGET(N), .GADGET_BIT_CNT(GB), .PIXELX_BIT_CNT(XB), .PIXELY_BIT_CNT(YB)
    ) bus ();

    gadget_scheduler #(
        .N_GADGET(N), .GADGET_BIT_CNT(GB), .PIXELX_BIT_CNT(XB), .PIXELY_BIT_CNT(YB),
        .SERVE_TMO(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cal_frame  (cal),
        .o_frame_done (o_fd),
        .o_busy       (o_busy),
        .o_err_tmo    (o_err),
        .bus          (bus)
    );

    typedef struct {
        logic          vld;
        logic [GB-1:0] typ;
        logic [XB-1:0] x;
        logic [YB-1:0] y;
        logic [N*GB-1:0] slots;
        logic [N-1:0]  gen;
        logic          drop;
    } spawn_vec_t;

    spawn_vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_req(input logic [N-1:0] exp, input string nm, output int lat);
        lat = 0;
        while (bus.o_gadget_req !== exp && lat < 100) begin
            tick();
            lat++;
        end
        chk(nm, 32'(bus.o_gadget_req), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int cnt;
        logic fd_seen;

        vecs[0]  = '{1'b1, 3'd2, 10'd100, 9'd50,  {3'd0, 3'd0, 3'd3, 3'd1}, 4'b0100, 1'b0};
        vecs[1]  = '{1'b1, 3'd5, 10'd7,   9'd8,   {3'd0, 3'd0, 3'd3, 3'd1}, 4'b1000, 1'b0};
        vecs[2]  = '{1'b1, 3'd1, 10'd9,   9'd9,   {3'd0, 3'd0, 3'd3, 3'd1}, 4'b0000, 1'b1};
        vecs[3]  = '{1'b1, 3'd1, 10'd9,   9'd9,   {3'd3, 3'd5, 3'd2, 3'd1}, 4'b0000, 1'b1};
        vecs[4]  = '{1'b1, 3'd0, 10'd9,   9'd9,   12'd0,                    4'b0000, 1'b0};
        vecs[5]  = '{1'b0, 3'd3, 10'd9,   9'd9,   12'd0,                    4'b0000, 1'b0};
        vecs[6]  = '{1'b1, 3'd7, 10'd1023, 9'd511, 12'd0,                   4'b0001, 1'b0};
        vecs[7]  = '{1'b1, 3'd4, 10'd0,   9'd0,   12'd0,                    4'b0010, 1'b0};
        vecs[8]  = '{1'b1, 3'd6, 10'd300, 9'd200, 12'd0,                    4'b0100, 1'b0};
        vecs[9]  = '{1'b1, 3'd1, 10'd512, 9'd256, 12'd0,                    4'b1000, 1'b0};
        vecs[10] = '{1'b1, 3'd2, 10'd5,   9'd5,   12'd0,                    4'b0000, 1'b1};

        bus.i_spawn_valid       = 1'b0;
        bus.i_spawn_type        = '0;
        bus.i_spawn_x           = '0;
        bus.i_spawn_y           = '0;
        bus.i_gadget_type       = '0;
        bus.i_gadget_ack        = '0;
        bus.i_gadget_frame_term = '0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_req",  32'(bus.o_gadget_req), 32'd0);
        chk("rst_gen",  32'(bus.o_gadget_gen), 32'd0);
        chk("rst_drop", 32'(bus.o_spawn_drop), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_fd",   32'(o_fd), 32'd0);
        chk("rst_err",  32'(o_err), 32'd0);
        rst = 1'b0;
        tick();

        // Spawn allocation table, FSM idle throughout
        for (int i = 0; i < 11; i++) begin
            bus.i_spawn_valid = vecs[i].vld;
            bus.i_spawn_type  = vecs[i].typ;
            bus.i_spawn_x     = vecs[i].x;
            bus.i_spawn_y     = vecs[i].y;
            bus.i_gadget_type = vecs[i].slots;
            tick();
            chk($sformatf("spawn%0d_gen", i),  32'(bus.o_gadget_gen), 32'(vecs[i].gen));
            chk($sformatf("spawn%0d_drop", i), 32'(bus.o_spawn_drop), 32'(vecs[i].drop));
            if (vecs[i].gen != 4'b0000) begin
                chk($sformatf("spawn%0d_x", i),    32'(bus.o_gadget_initX), 32'(vecs[i].x));
                chk($sformatf("spawn%0d_y", i),    32'(bus.o_gadget_initY), 32'(vecs[i].y));
                chk($sformatf("spawn%0d_type", i), 32'(bus.o_gadget_type),  32'(vecs[i].typ));
            end
        end
        bus.i_spawn_valid = 1'b0;
        tick();
        chk("spawn_gen_fall",  32'(bus.o_gadget_gen), 32'd0);
        chk("spawn_drop_fall", 32'(bus.o_spawn_drop), 32'd0);
        bus.i_gadget_type = {3'd1, 3'd1, 3'd1, 3'd1};
        tick();
        bus.i_gadget_type = '0;
        tick();

        // All slots empty: frame_done N+2 cycles after the strobe, no req
        cal = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            cal = 1'b0;
            chk($sformatf("empty_fd_%0d", k),   32'(o_fd),   32'(k == 6));
            chk($sformatf("empty_busy_%0d", k), 32'(o_busy), 32'(k <= 6));
            chk($sformatf("empty_req_%0d", k),  32'(bus.o_gadget_req), 32'd0);
        end

        // Slots 1 and 3 live
        bus.i_gadget_type = {3'd4, 3'd0, 3'd2, 3'd0};
        bus.i_gadget_ack  = 4'b1111;
        cal = 1'b1;
        tick();
        cal = 1'b0;
        bus.i_gadget_ack = 4'b0000;
        wait_req(4'b0010, "live_req1", lat);
        chk("live_req1_lat", 32'(lat), 32'd2);
        bus.i_gadget_ack = 4'b0010;
        tick();
        bus.i_gadget_ack        = 4'b1101;
        bus.i_gadget_frame_term = 4'b1001;
        tick();
        bus.i_gadget_ack        = 4'b0000;
        bus.i_gadget_frame_term = 4'b0000;
        chk("live_foreign_term", 32'(bus.o_gadget_req), 32'b0010);
        bus.i_gadget_frame_term = 4'b0010;
        tick();
        bus.i_gadget_frame_term = 4'b0000;
        chk("live_req1_drop", 32'(bus.o_gadget_req), 32'd0);
        tick();
        chk("live_scan2", 32'(bus.o_gadget_req), 32'd0);
        tick();
        chk("live_req3", 32'(bus.o_gadget_req), 32'b1000);
        tick();
        chk("live_req3_hold", 32'(bus.o_gadget_req), 32'b1000);
        bus.i_gadget_frame_term = 4'b1000;
        tick();
        bus.i_gadget_frame_term = 4'b0000;
        chk("live_req3_drop", 32'(bus.o_gadget_req), 32'd0);
        chk("live_fd_early",  32'(o_fd), 32'd0);
        tick();
        chk("live_fd",   32'(o_fd), 32'd1);
        chk("live_busy", 32'(o_busy), 32'd1);
        tick();
        chk("live_fd_fall",   32'(o_fd), 32'd0);
        chk("live_busy_fall", 32'(o_busy), 32'd0);

        // Slot 1 never terminates: abandoned after SERVE_TMO cycles
        bus.i_gadget_type = {3'd0, 3'd1, 3'd3, 3'd0};
        cal = 1'b1;
        tick();
        cal = 1'b0;
        wait_req(4'b0010, "tmo_req1", lat);
        chk("tmo_err_before", 32'(o_err), 32'd0);
        cnt = 1;
        for (int g = 0; g < 200; g++) begin
            if (cnt == 10) cal = 1'b1;
            tick();
            cal = 1'b0;
            if (bus.o_gadget_req == 4'b0010) cnt++;
            else break;
        end
        chk("tmo_req_cycles", 32'(cnt), 32'(TMO));
        chk("tmo_req_drop",   32'(bus.o_gadget_req), 32'd0);
        chk("tmo_err_set",    32'(o_err), 32'd1);
        tick();
        chk("tmo_next_slot", 32'(bus.o_gadget_req), 32'b0100);
        bus.i_gadget_frame_term = 4'b0100;
        tick();
        bus.i_gadget_frame_term = 4'b0000;
        chk("tmo_req2_drop", 32'(bus.o_gadget_req), 32'd0);
        tick();
        tick();
        chk("tmo_fd", 32'(o_fd), 32'd1);
        tick();
        chk("tmo_idle", 32'(o_busy), 32'd0);
        tick();
        tick();
        chk("tmo_not_queued", 32'(o_busy), 32'd0);
        chk("tmo_err_sticky", 32'(o_err), 32'd1);

        // Reset in the middle of serving slot 2
        bus.i_gadget_type = {3'd0, 3'd1, 3'd0, 3'd0};
        cal = 1'b1;
        tick();
        cal = 1'b0;
        wait_req(4'b0100, "mid_req2", lat);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_req",  32'(bus.o_gadget_req), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_fd",   32'(o_fd), 32'd0);
        chk("mid_rst_err",  32'(o_err), 32'd0);
        fd_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            fd_seen = fd_seen | o_fd | o_busy;
        end
        chk("mid_rst_quiet", 32'(fd_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
